// File: rtl/text_console_if.sv
// text_console_if: character handshake between the CPU console register
// and the text console front end.
interface text_console_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       busy;

  modport master (output in_valid, output in_char, input in_ready, input busy);
  modport slave  (input in_valid, input in_char, output in_ready, output busy);
endinterface

// File: rtl/text_console.sv
// text_console: 80x30 character cell buffer with cursor tracking, line wrap,
// backspace, form-feed clear and a registered painter read port.
// Optional hardware scrolling is enabled by defining TEXT_CONSOLE_SCROLL_EN;
// without it the cursor wraps from the last row back to row 0.
module text_console #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  text_console_if.slave    cpu,
  input  logic [4:0]       rd_row,
  input  logic [6:0]       rd_col,
  output logic [6:0]       rd_data,
  output logic [4:0]       cur_row,
  output logic [6:0]       cur_col
);

  localparam int              CELLS     = ROWS * COLS;
  localparam int              AW        = $clog2(CELLS);
  localparam logic [6:0]      BLANK     = 7'h20;
  localparam logic [4:0]      LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0]      LAST_COL  = 7'(COLS - 1);
  localparam logic [AW-1:0]   LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0]   ROW_END   = AW'(COLS - 1);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] sweep, sweep_nx;
  logic [4:0]    clr_row, clr_row_nx;
  logic [4:0]    top_row, top_row_nx;
  logic [4:0]    cur_row_nx;
  logic [6:0]    cur_col_nx;
  logic          advance;

  logic          we;
  logic [AW-1:0] waddr;
  logic [6:0]    wdata;

  logic [4:0]    rd_phys;
  logic          rd_hit;

  logic [6:0]    mem [CELLS];

  // Logical row to physical row; the sum never exceeds 2*ROWS-2, so one
  // conditional subtract replaces the modulo.
  function automatic logic [4:0] to_phys(input logic [4:0] r, input logic [4:0] top);
    logic [5:0] s;
    s = {1'b0, r} + {1'b0, top};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  assign cpu.in_ready = (state == IDLE);
  assign cpu.busy     = (state != IDLE);

  // State, sweep counter, cursor and scroll origin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ALL;
      sweep   <= '0;
      clr_row <= '0;
      top_row <= '0;
      cur_row <= '0;
      cur_col <= '0;
    end else begin
      state   <= state_nx;
      sweep   <= sweep_nx;
      clr_row <= clr_row_nx;
      top_row <= top_row_nx;
      cur_row <= cur_row_nx;
      cur_col <= cur_col_nx;
    end
  end

  // Next-state, cursor update and the single cell write port.
  always_comb begin
    state_nx   = state;
    sweep_nx   = sweep;
    clr_row_nx = clr_row;
    top_row_nx = top_row;
    cur_row_nx = cur_row;
    cur_col_nx = cur_col;
    advance    = 1'b0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = BLANK;

    unique case (state)
      CLEAR_ALL: begin
        we    = 1'b1;
        waddr = sweep;
        if (sweep == LAST_CELL) begin
          state_nx = IDLE;
          sweep_nx = '0;
        end else begin
          sweep_nx = sweep + 1'b1;
        end
      end

      CLEAR_ROW: begin
        we    = 1'b1;
        waddr = cell_addr(clr_row, sweep[6:0]);
        if (sweep == ROW_END) begin
          state_nx = IDLE;
          sweep_nx = '0;
        end else begin
          sweep_nx = sweep + 1'b1;
        end
      end

      IDLE: begin
        if (cpu.in_valid) begin
          case (cpu.in_char)
            8'h0A: begin
              cur_col_nx = '0;
              advance    = 1'b1;
            end
            8'h0D: cur_col_nx = '0;
            8'h08: begin
              if (cur_col != '0) begin
                cur_col_nx = cur_col - 1'b1;
                we         = 1'b1;
                waddr      = cell_addr(to_phys(cur_row, top_row), cur_col - 1'b1);
              end
            end
            8'h0C: begin
              cur_row_nx = '0;
              cur_col_nx = '0;
              top_row_nx = '0;
              sweep_nx   = '0;
              state_nx   = CLEAR_ALL;
            end
            default: begin
              if (cpu.in_char >= 8'h20 && cpu.in_char <= 8'h7E) begin
                we    = 1'b1;
                wdata = cpu.in_char[6:0];
                waddr = cell_addr(to_phys(cur_row, top_row), cur_col);
                if (cur_col == LAST_COL) begin
                  cur_col_nx = '0;
                  advance    = 1'b1;
                end else begin
                  cur_col_nx = cur_col + 1'b1;
                end
              end
            end
          endcase

          if (advance) begin
            if (cur_row != LAST_ROW) begin
              cur_row_nx = cur_row + 1'b1;
            end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
              // The old top physical row becomes the new bottom logical row.
              top_row_nx = (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
              clr_row_nx = top_row;
`else
              cur_row_nx = '0;
              clr_row_nx = '0;
`endif
              sweep_nx = '0;
              state_nx = CLEAR_ROW;
            end
          end
        end
      end

      default: begin
        state_nx = CLEAR_ALL;
        sweep_nx = '0;
      end
    endcase
  end

  // Cell storage write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_phys = to_phys(rd_row, top_row);
  assign rd_hit  = (rd_row < 5'(ROWS)) && (rd_col < 7'(COLS));

  // Registered painter read; same-cycle writes are not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_hit) rd_data <= mem[cell_addr(rd_phys, rd_col)];
    else rd_data <= '0;
  end

endmodule

// File: tb/tb_text_console.sv
// tb_text_console: table vectors, hand sequences and randomized character
// streams checked against a logical-screen model of the console.
`timescale 1ns/1ps
module tb_text_console;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int FULL = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rd_row;
  logic [6:0] rd_col;
  logic [6:0] rd_data;
  logic [4:0] cur_row;
  logic [6:0] cur_col;

  text_console_if io();

  text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu     (io),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data),
    .cur_row (cur_row),
    .cur_col (cur_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall  = 0;

  // Logical screen as the user sees it, plus the cursor.
  logic [6:0] mdl [ROWS][COLS];
  int mrow, mcol;

  typedef struct {
    logic [7:0] c;
    int         row;
    int         col;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void blank_row(input int r);
    for (int c = 0; c < COLS; c++) mdl[r][c] = 7'h20;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++) blank_row(r);
    mrow = 0;
    mcol = 0;
  endfunction

  // Returns the number of cycles the console is expected to stay busy.
  function automatic int adv_line();
    if (mrow < ROWS - 1) begin
      mrow++;
      return 0;
    end
`ifdef TEXT_CONSOLE_SCROLL_EN
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = mdl[r+1][c];
    blank_row(ROWS - 1);
`else
    mrow = 0;
    blank_row(0);
`endif
    return COLS;
  endfunction

  function automatic int model_apply(input logic [7:0] c);
    int blen = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      mdl[mrow][mcol] = c[6:0];
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        blen = adv_line();
      end
    end else if (c == 8'h0A) begin
      mcol = 0;
      blen = adv_line();
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        mdl[mrow][mcol] = 7'h20;
      end
    end else if (c == 8'h0C) begin
      model_clear();
      blen = FULL;
    end
    return blen;
  endfunction

  task automatic measure_busy(input int exp, input string tag);
    int n = 0;
    while (!io.in_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, exp);
  endtask

  // Holds in_valid/in_char until the transfer edge, then checks cursor and
  // the busy window against the model.
  task automatic send_char(input logic [7:0] c, input string tag);
    int n = 0;
    int blen;
    io.in_valid = 1'b1;
    io.in_char  = c;
    while (!io.in_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    stall += n;
    if (n >= 5000) chk({tag, "_ready_timeout"}, n, 0);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    blen = model_apply(c);
    chk({tag, "_cur_row"}, int'(cur_row), mrow);
    chk({tag, "_cur_col"}, int'(cur_col), mcol);
    measure_busy(blen, {tag, "_busy"});
  endtask

  task automatic read_cell(input int r, input int c, output logic [6:0] d);
    rd_row = 5'(r);
    rd_col = 7'(c);
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic chk_cell(input int r, input int c, input int exp, input string tag);
    logic [6:0] d;
    read_cell(r, c, d);
    chk(tag, int'(d), exp);
  endtask

  task automatic check_screen(input string tag);
    int mism = 0;
    logic [6:0] d;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, d);
        if (d !== mdl[r][c]) mism++;
      end
    chk({tag, "_cells_differing"}, mism, 0);
  endtask

  task automatic check_row_blank(input int r, input string tag);
    int mism = 0;
    logic [6:0] d;
    for (int c = 0; c < COLS; c++) begin
      read_cell(r, c, d);
      if (d !== 7'h20) mism++;
    end
    chk(tag, mism, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[14];
    logic [6:0] d;
    logic [7:0] ch;
    int n, ff_left, sel;

    vecs[0]  = '{8'h08, 0, 1};
    vecs[1]  = '{8'h0D, 0, 0};
    vecs[2]  = '{8'h08, 0, 0};
    vecs[3]  = '{8'h0A, 1, 0};
    vecs[4]  = '{8'h85, 1, 0};
    vecs[5]  = '{8'h00, 1, 0};
    vecs[6]  = '{8'h7F, 1, 0};
    vecs[7]  = '{8'h7E, 1, 1};
    vecs[8]  = '{8'h20, 1, 2};
    vecs[9]  = '{8'h61, 1, 3};
    vecs[10] = '{8'h62, 1, 4};
    vecs[11] = '{8'h63, 1, 5};
    vecs[12] = '{8'h08, 1, 4};
    vecs[13] = '{8'h0A, 2, 0};

    io.in_valid = 1'b0;
    io.in_char  = 8'h00;
    rd_row = '0;
    rd_col = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(io.in_ready), 0);
    chk("reset_busy", int'(io.busy), 1);
    chk("reset_cur_row", int'(cur_row), 0);
    chk("reset_cur_col", int'(cur_col), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    model_clear();
    measure_busy(FULL, "reset_clear_len");
    check_screen("reset_screen");

    // 'A','B' and one-cycle read latency
    send_char("A", "A");
    send_char("B", "B");
    chk("ab_cur_col", int'(cur_col), 2);
    rd_row = 5'd0; rd_col = 7'd0;
    @(posedge clk); #1;
    chk("rd_00", int'(rd_data), 8'h41);
    rd_col = 7'd1;
    #1;
    chk("rd_latency_old", int'(rd_data), 8'h41);
    @(posedge clk); #1;
    chk("rd_latency_new", int'(rd_data), 8'h42);

    // Table of control codes and printable characters
    for (int i = 0; i < 14; i++) begin
      send_char(vecs[i].c, "vec");
      chk($sformatf("vec%0d_row", i), int'(cur_row), vecs[i].row);
      chk($sformatf("vec%0d_col", i), int'(cur_col), vecs[i].col);
    end
    chk_cell(0, 0, 8'h41, "cell_0_0");
    chk_cell(0, 1, 8'h20, "cell_0_1_bs");
    chk_cell(1, 0, 8'h7E, "cell_1_0");
    chk_cell(1, 2, 8'h61, "cell_1_2");
    chk_cell(1, 3, 8'h62, "cell_1_3");
    chk_cell(1, 4, 8'h20, "cell_1_4_bs");
    chk_cell(30, 0, 0, "oob_row");
    chk_cell(0, 80, 0, "oob_col");
    chk_cell(31, 127, 0, "oob_both");

    // Read of the cell written on the same edge returns old contents
    rd_row = 5'd2; rd_col = 7'd0;
    @(posedge clk); #1;
    send_char("W", "W");
    chk("rd_old_on_write", int'(rd_data), 8'h20);
    @(posedge clk); #1;
    chk("rd_new_after_write", int'(rd_data), 8'h57);

    // 80 x 'x' fills a row and wraps without stalling
    send_char(8'h0D, "cr");
    stall = 0;
    for (int i = 0; i < COLS; i++) send_char("x", "x80");
    chk("x80_stall", stall, 0);
    chk("x80_cur_row", int'(cur_row), 3);
    chk("x80_cur_col", int'(cur_col), 0);
    n = 0;
    for (int c = 0; c < COLS; c++) begin
      read_cell(2, c, d);
      if (d !== 7'h78) n++;
    end
    chk("x80_row_cells", n, 0);
    check_screen("basic_screen");

    // FF with in_valid held during the clear: nothing consumed
    io.in_valid = 1'b1;
    io.in_char  = 8'h0C;
    @(posedge clk); #1;
    void'(model_apply(8'h0C));
    io.in_char = "Q";
    n = 0;
    while (!io.in_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    io.in_valid = 1'b0;
    chk("ff_hold_clear_len", n, FULL);
    chk("ff_hold_cur_row", int'(cur_row), 0);
    chk("ff_hold_cur_col", int'(cur_col), 0);
    check_screen("ff_screen");

    // Reset asserted 1000 cycles into an FF clear
    send_char("R", "R");
    send_char("S", "S");
    rd_row = 5'd0; rd_col = 7'd0;
    io.in_valid = 1'b1;
    io.in_char  = 8'h0C;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("midclear_partial_read", int'(rd_data), 8'h20);
    chk("midclear_in_ready", int'(io.in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("midclear_rst_rd_data", int'(rd_data), 0);
    chk("midclear_rst_busy", int'(io.busy), 1);
    chk("midclear_rst_cur_col", int'(cur_col), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    measure_busy(FULL, "midclear_restart_len");
    check_screen("midclear_screen");

    // "Lk" + LF for k = 0..29
    for (int k = 0; k < ROWS; k++) begin
      send_char("L", "lk");
      if (k >= 10) send_char(8'(8'h30 + k / 10), "lk");
      send_char(8'(8'h30 + k % 10), "lk");
      send_char(8'h0A, $sformatf("lf%0d", k));
    end
`ifdef TEXT_CONSOLE_SCROLL_EN
    chk("scroll_cur_row", int'(cur_row), 29);
    chk("scroll_cur_col", int'(cur_col), 0);
    chk_cell(0, 0, 8'h4C, "scroll_r0_c0");
    chk_cell(0, 1, 8'h31, "scroll_r0_c1");
    chk_cell(0, 2, 8'h20, "scroll_r0_c2");
    chk_cell(28, 1, 8'h32, "scroll_r28_c1");
    chk_cell(28, 2, 8'h39, "scroll_r28_c2");
    check_row_blank(29, "scroll_r29_blank");
`else
    chk("wrap_cur_row", int'(cur_row), 0);
    chk("wrap_cur_col", int'(cur_col), 0);
    check_row_blank(0, "wrap_r0_blank");
    chk_cell(1, 0, 8'h4C, "wrap_r1_c0");
    chk_cell(1, 1, 8'h31, "wrap_r1_c1");
    chk_cell(29, 1, 8'h32, "wrap_r29_c1");
    chk_cell(29, 2, 8'h39, "wrap_r29_c2");
`endif
    check_screen("lines_screen");

    // Randomized stream with spot reads
    ff_left = 2;
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 199);
      if (sel < 140)      ch = 8'($urandom_range(32, 126));
      else if (sel < 160) ch = 8'h0A;
      else if (sel < 170) ch = 8'h0D;
      else if (sel < 184) ch = 8'h08;
      else if (sel < 198) begin
        case ($urandom_range(0, 4))
          0: ch = 8'h00;
          1: ch = 8'h7F;
          2: ch = 8'h85;
          3: ch = 8'hFF;
          default: ch = 8'h1B;
        endcase
      end else if (ff_left > 0) begin
        ch = 8'h0C;
        ff_left--;
      end else ch = 8'h41;
      send_char(ch, "rnd");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if (i % 10 == 0) begin
        n = $urandom_range(0, ROWS - 1);
        sel = $urandom_range(0, COLS - 1);
        read_cell(n, sel, d);
        chk($sformatf("rnd_read_%0d_%0d", n, sel), int'(d), int'(mdl[n][sel]));
      end
    end
    check_screen("random_screen");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
